// File: rtl/ib_lut_pkg.sv
// Shared definitions for the IB-VNU LUT loader and the IB RAM wrappers:
// loader FSM states, page-count derivation and LUT word width.
package ib_lut_pkg;

  localparam int LUT_PORT_SIZE_D = 3;
  localparam int BANK_NUM_D      = 2;
  localparam int LUT_WORD_W      = LUT_PORT_SIZE_D * BANK_NUM_D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  // The page address MSB selects the slot, so each slot holds 2^(ENTRY_ADDR-1) pages.
  function automatic int page_num(input int entry_addr);
    return 1 << (entry_addr - 1);
  endfunction

endpackage

// File: rtl/ib_slot_pingpong.sv
// Active-slot ping-pong: toggles the read slot only while the loader is idle,
// deferring any swap request that arrives during (or with the start of) a load.
module ib_slot_pingpong
  import ib_lut_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic swap_req,
  input  logic idle,
  input  logic load_start,
  output logic read_addr_offset,
  output logic swap_pending,
  output logic active_next
);

  logic toggle_now;

  // A start in the same idle cycle wins; the swap is parked until the load ends.
  assign toggle_now  = idle & (swap_pending | (swap_req & ~load_start));
  assign active_next = read_addr_offset ^ toggle_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr_offset <= 1'b0;
      swap_pending     <= 1'b0;
    end else begin
      read_addr_offset <= active_next;
      if (toggle_now)
        swap_pending <= 1'b0;
      else if (swap_req)
        swap_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/ib_vnu_lut_loader.sv
// Streams one iteration's LUT words into the inactive slot of the IB-VNU LUT RAMs
// and exports the active slot to the read datapath.
module ib_vnu_lut_loader
  import ib_lut_pkg::*;
#(
  parameter int LUT_PORT_SIZE   = LUT_PORT_SIZE_D,
  parameter int BANK_NUM        = BANK_NUM_D,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int ITER_MAX        = 8
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data,
  input  logic                              lut_valid,
  output logic                              lut_ready,
  input  logic                              swap_req,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              read_addr_offset,
  output logic                              load_busy,
  output logic                              load_done,
  output logic                              swap_pending,
  output logic [$clog2(ITER_MAX)-1:0]       iter_cnt
);

  localparam int PAGE_W   = ENTRY_ADDR - 1;
  localparam int PAGE_NUM = page_num(ENTRY_ADDR);
  localparam int ITER_W   = $clog2(ITER_MAX);
  localparam int SLOT_W   = $clog2(MULTI_FRAME_NUM);

  load_state_t       state;
  logic [PAGE_W-1:0] page_cnt;
  logic [SLOT_W-1:0] write_slot;
  logic              idle;
  logic              active_next;
  logic              beat;
  logic              last_beat;

  assign idle      = (state == ST_IDLE);
  assign beat      = (state == ST_LOAD) & lut_valid & lut_ready;
  assign last_beat = beat & (page_cnt == PAGE_W'(PAGE_NUM - 1));

  ib_slot_pingpong u_pingpong (
    .clk              (write_clk),
    .rst              (rst),
    .swap_req         (swap_req),
    .idle             (idle),
    .load_start       (load_start),
    .read_addr_offset (read_addr_offset),
    .swap_pending     (swap_pending),
    .active_next      (active_next)
  );

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      page_cnt         <= '0;
      write_slot       <= '0;
      lut_ready        <= 1'b0;
      load_busy        <= 1'b0;
      load_done        <= 1'b0;
      ib_ram_we        <= 1'b0;
      page_addr_ram    <= '0;
      ram_write_data_1 <= '0;
      iter_cnt         <= '0;
    end else begin
      ib_ram_we <= 1'b0;
      load_done <= 1'b0;

      // Write port stage: address/data/strobe presented one cycle after the beat.
      if (beat) begin
        ram_write_data_1 <= lut_data;
        page_addr_ram    <= {write_slot, page_cnt};
        ib_ram_we        <= 1'b1;
        page_cnt         <= page_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            page_cnt   <= '0;
            write_slot <= SLOT_W'(~active_next);
            lut_ready  <= 1'b1;
            load_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (last_beat) begin
            state     <= ST_DONE;
            lut_ready <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b1;
            iter_cnt  <= (iter_cnt == ITER_W'(ITER_MAX - 1)) ? '0 : iter_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
